// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// word size and a redirect alignment helper.
package pc_seq_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      DRAIN = 3'd3,
      HOLD  = 3'd4,
      FAULT = 3'd5
   } pc_state_e;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_sequencer_adder.sv
// AdderPC: sequential-fetch increment, pc + INSTR_BYTES modulo 2^XLEN.
module AdderPC
   import pc_seq_pkg::*;
(
   input  logic [XLEN-1:0] pc_in,
   output logic [XLEN-1:0] pc_plus4
);

   assign pc_plus4 = pc_in + XLEN'(INSTR_BYTES);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Build option: PC_MISALIGN_CHECK_EN enables misaligned-redirect detection and the FAULT state.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready,
   output logic            misalign,
   output logic [XLEN-1:0] misalign_pc
);

   pc_state_e       state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt, pc_plus4;
   logic [XLEN-1:0] redir_pc;
   logic            redir_bad;
   logic            fault_pend, fault_pend_nxt;
   logic            latch;
   pc_state_e       dest;

   AdderPC u_adder (
      .pc_in    (pc),
      .pc_plus4 (pc_plus4)
   );

`ifdef PC_MISALIGN_CHECK_EN
   assign redir_pc  = redirect_pc;
   assign redir_bad = redirect_valid && is_misaligned(redirect_pc);
`else
   // Without the check the low bits are simply dropped.
   assign redir_pc  = redirect_pc & ~XLEN'(3);
   assign redir_bad = 1'b0;
`endif

   assign dest = redir_bad ? FAULT : REQ;

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      fault_pend_nxt = fault_pend;
      latch          = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = REQ;
            if (redirect_valid) begin
               pc_nxt    = redir_pc;
               state_nxt = dest;
            end
         end
         REQ: begin
            if (redirect_valid) begin
               pc_nxt = redir_pc;
               if (imem_gnt) begin
                  state_nxt      = DRAIN;
                  fault_pend_nxt = redir_bad;
               end else begin
                  state_nxt = dest;
               end
            end else if (imem_gnt) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_nxt = redir_pc;
               if (imem_rvalid) begin
                  state_nxt = dest;
               end else begin
                  state_nxt      = DRAIN;
                  fault_pend_nxt = redir_bad;
               end
            end else if (imem_rvalid) begin
               latch     = 1'b1;
               pc_nxt    = pc_plus4;
               state_nxt = HOLD;
            end
         end
         DRAIN: begin
            // The latest redirect decides where we land once the stale word is gone.
            if (redirect_valid) begin
               pc_nxt         = redir_pc;
               fault_pend_nxt = redir_bad;
            end
            if (imem_rvalid)
               state_nxt = (redirect_valid ? redir_bad : fault_pend) ? FAULT : REQ;
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_nxt    = redir_pc;
               state_nxt = dest;
            end else if (instr_ready) begin
               state_nxt = REQ;
            end
         end
         FAULT: begin
            if (redirect_valid) begin
               pc_nxt    = redir_pc;
               state_nxt = dest;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         fault_pend <= 1'b0;
         instr      <= '0;
         instr_pc   <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         fault_pend <= fault_pend_nxt;
         if (latch) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
         end
      end
   end

   // Moore outputs: decoded from flops only.
   assign imem_req    = (state == REQ);
   assign imem_addr   = pc;
   assign instr_valid = (state == HOLD);

`ifdef PC_MISALIGN_CHECK_EN
   logic [XLEN-1:0] mis_pc_q;

   always_ff @(posedge clk) begin
      if (!rst)
         mis_pc_q <= '0;
      else if (redir_bad)
         mis_pc_q <= redir_pc;
   end

   assign misalign    = (state == FAULT);
   assign misalign_pc = mis_pc_q;
`else
   assign misalign    = 1'b0;
   assign misalign_pc = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scoreboarded fetches, hold, redirects, misalign, wrap, reset.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        misalign;
   logic [31:0] misalign_pc;

   int tests = 0;
   int fails = 0;
   logic [63:0] sb[$];

   pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .misalign       (misalign),
      .misalign_pc    (misalign_pc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_req(input string name, input logic exp_req, input logic [31:0] exp_addr);
      tests++;
      if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin
         fails++;
         $display("FAIL %s: req=%0b addr=%h, want req=%0b addr=%h", name, imem_req, imem_addr, exp_req, exp_addr);
      end
   endtask

   task automatic chk_no_instr(input string name);
      tests++;
      if (instr_valid !== 1'b0) begin
         fails++;
         $display("FAIL %s: instr_valid=%0b, want 0", name, instr_valid);
      end
   endtask

   task automatic chk_reset_outs(input string name);
      tests++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h100 || instr_valid !== 1'b0 || instr !== 32'h0 ||
          instr_pc !== 32'h0 || misalign !== 1'b0 || misalign_pc !== 32'h0) begin
         fails++;
         $display("FAIL %s: req=%0b addr=%h iv=%0b instr=%h ipc=%h mis=%0b mpc=%h, want 0/100/0/0/0/0/0",
                  name, imem_req, imem_addr, instr_valid, instr, instr_pc, misalign, misalign_pc);
      end
   endtask

   // Wait for a request, check address, grant, return data, and check the buffered word.
   task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
      logic [63:0] e;
      int n = 0;
      while (imem_req !== 1'b1 && n < 10) begin tick(); n++; end
      chk_req("fetch_addr", 1'b1, exp_addr);
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      sb.push_back({data, exp_addr});
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      tests++;
      if (instr_valid !== 1'b1 || sb.size() == 0) begin
         fails++;
         $display("FAIL fetch_valid: instr_valid=%0b queued=%0d, want 1", instr_valid, sb.size());
      end else begin
         e = sb.pop_front();
         if (instr !== e[63:32] || instr_pc !== e[31:0]) begin
            fails++;
            $display("FAIL fetch_data: instr=%h pc=%h, want instr=%h pc=%h", instr, instr_pc, e[63:32], e[31:0]);
         end
      end
   endtask

   task automatic accept(input logic [31:0] next_addr);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk_req("accept_next", 1'b1, next_addr);
   endtask

   task automatic test_reset();
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      tick(); tick();
      chk_reset_outs("reset_vals");
      rst = 1'b1;
      tick();
      chk_req("reset_first_req", 1'b1, 32'h100);
   endtask

   task automatic test_basic_fetch();
      do_fetch(32'h100, 32'h0000_0013);
      accept(32'h104);
   endtask

   task automatic test_hold();
      logic [31:0] i0, p0;
      do_fetch(32'h104, 32'h0040_0093);
      i0 = 32'h0040_0093; p0 = 32'h104;
      for (int k = 0; k < 5; k++) begin
         tick();
         tests++;
         if (instr_valid !== 1'b1 || instr !== i0 || instr_pc !== p0 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL hold_stable: iv=%0b instr=%h pc=%h req=%0b, want 1/%h/%h/0", instr_valid, instr, instr_pc, imem_req, i0, p0);
         end
      end
      accept(32'h108);
   endtask

   task automatic test_redirect_wait();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      chk_req("drain_no_req", 1'b0, 32'h0);
      chk_no_instr("drain_no_instr");
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
      tick();
      imem_rvalid = 1'b0;
      chk_req("after_drain", 1'b1, 32'h200);
      chk_no_instr("dropped_word");
      do_fetch(32'h200, 32'h1111_1111);
      accept(32'h204);
   endtask

   task automatic test_redirect_rvalid();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      tick();
      imem_rvalid = 1'b0; redirect_valid = 1'b0;
      chk_req("redir_rvalid_req", 1'b1, 32'h300);
      chk_no_instr("redir_rvalid_drop");
      do_fetch(32'h300, 32'h2222_2222);
      accept(32'h304);
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_pc = 32'h202;
      tick();
      redirect_valid = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (misalign !== 1'b1 || misalign_pc !== 32'h202 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL misalign_fault: mis=%0b mpc=%h req=%0b, want 1/202/0", misalign, misalign_pc, imem_req);
         end
         tick();
      end
      redirect_valid = 1'b1; redirect_pc = 32'h400;
      tick();
      redirect_valid = 1'b0;
      tests++;
      if (misalign !== 1'b0) begin
         fails++;
         $display("FAIL misalign_exit: mis=%0b, want 0", misalign);
      end
      chk_req("misalign_exit_req", 1'b1, 32'h400);
      do_fetch(32'h400, 32'h3333_3333);
      accept(32'h404);
`else
      tests++;
      if (misalign !== 1'b0 || misalign_pc !== 32'h0) begin
         fails++;
         $display("FAIL misalign_tied: mis=%0b mpc=%h, want 0/0", misalign, misalign_pc);
      end
      chk_req("misalign_forced", 1'b1, 32'h200);
      do_fetch(32'h200, 32'h3333_3333);
      accept(32'h204);
`endif
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      do_fetch(32'hFFFF_FFFC, 32'h4444_4444);
      accept(32'h0000_0000);
   endtask

   task automatic test_reset_mid_wait();
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      rst = 1'b0;
      tick();
      chk_reset_outs("reset_mid_wait");
      rst = 1'b1;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
      tick();
      imem_rvalid = 1'b0;
      chk_req("reset_stray_rvalid", 1'b1, 32'h100);
      chk_no_instr("reset_stray_drop");
      tick();
      chk_req("reset_stays_req", 1'b1, 32'h100);
      do_fetch(32'h100, 32'h5555_5555);
      accept(32'h104);
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_hold();
      test_redirect_wait();
      test_redirect_rvalid();
      test_misalign();
      test_wrap();
      test_reset_mid_wait();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_empty: %0d left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
